// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end: opcodes, flag bit
// positions, command word layout and the issue FSM state type.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    // Bit positions inside the 3-bit response flag vector {carry, zero, overflow}.
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    // Command word stored in the FIFO: {op[10:8], a[7:4], b[3:0]}.
    localparam int CMD_W = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Opcodes above XOR have no ALU function and must never reach the response path.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH x CMD_W storage, wrapping pointers, registered
// full/empty/count. A push is dropped when full even if a pop happens in the
// same cycle, so the full flag alone decides acceptance.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [CMD_W-1:0]           push_data,
    input  logic                       pop,
    output logic [CMD_W-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Occupancy after this edge; full/empty are registered from it.
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Pointers and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_nxt;
            full  <= (count_nxt == CNT_FULL);
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset; entries are only read while marked occupied.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command front-end for the combinational 4-bit ALU: buffers commands,
// issues one at a time through registered operands, and holds the result
// in a response register until the consumer takes it.
//
// state | meaning
// IDLE  | nothing in flight; pops the FIFO head as soon as one is present
// EXEC  | operands applied to the ALU; result captured at the next edge
// RESP  | response held on RSP_*; on RSP_READY issue the next command or go idle
module alu_cmd_issue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       CMD_VALID,
    output logic                       CMD_READY,
    input  logic [3:0]                 CMD_A,
    input  logic [3:0]                 CMD_B,
    input  logic [2:0]                 CMD_OP,
    output logic [$clog2(DEPTH):0]     CMD_COUNT,
    output logic [3:0]                 ALU_A,
    output logic [3:0]                 ALU_B,
    output logic [2:0]                 ALU_CTRL,
    input  logic [3:0]                 ALU_RESULT,
    input  logic                       ALU_CARRY,
    input  logic                       ALU_ZERO,
    input  logic                       ALU_OVF,
    output logic                       RSP_VALID,
    input  logic                       RSP_READY,
    output logic [3:0]                 RSP_RESULT,
    output logic [2:0]                 RSP_FLAGS,
    output logic                       RSP_ERR
);

    state_t           state;
    state_t           state_nxt;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_head;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (CMD_VALID),
        .push_data ({CMD_OP, CMD_A, CMD_B}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (CMD_COUNT)
    );

    assign CMD_READY = !fifo_full;
    assign RSP_VALID = (state == RESP);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and FIFO pop; a pop always coincides with entering EXEC.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (RSP_READY) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers; they keep the last issued command while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_A    <= '0;
            ALU_B    <= '0;
            ALU_CTRL <= '0;
        end else if (fifo_pop) begin
            ALU_CTRL <= fifo_head[10:8];
            ALU_A    <= fifo_head[7:4];
            ALU_B    <= fifo_head[3:0];
        end
    end

    // Response capture; illegal opcodes never sample the (possibly X) ALU outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RSP_RESULT <= '0;
            RSP_FLAGS  <= '0;
            RSP_ERR    <= 1'b0;
        end else if (state == EXEC) begin
            if (is_legal_op(ALU_CTRL)) begin
                RSP_RESULT        <= ALU_RESULT;
                RSP_FLAGS[FLAG_C] <= ALU_CARRY;
                RSP_FLAGS[FLAG_Z] <= ALU_ZERO;
                RSP_FLAGS[FLAG_V] <= ALU_OVF;
                RSP_ERR           <= 1'b0;
            end else begin
                RSP_RESULT <= '0;
                RSP_FLAGS  <= '0;
                RSP_ERR    <= 1'b1;
            end
        end
    end

endmodule
